// File: rtl/vector_store_unit_pkg.sv
// Shared vector definitions: default vector geometry and the store-unit state encoding.
package vector_store_unit_pkg;

   // Default number of 8-bit lanes per vector and data-memory byte address width.
   localparam int VEC_LANES  = 16;
   localparam int VEC_ADDR_W = 12;

   // Store sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } vsu_state_e;

endpackage

// File: rtl/vector_store_unit.sv
// Vector store unit: captures one vector store request and serialises it into
// byte writes to data memory, one lane per cycle, skipping masked-off lanes.
module vector_store_unit
   import vector_store_unit_pkg::*;
#(
   parameter int LANES  = VEC_LANES,
   parameter int ADDR_W = VEC_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st_valid,
   output logic                 st_ready,
   input  logic [ADDR_W-1:0]    st_base,
   input  logic [8*LANES-1:0]   st_data,
   input  logic [LANES-1:0]     st_mask,
   input  logic                 flush,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   vsu_state_e          state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [ADDR_W-1:0]   base_q;
   logic [8*LANES-1:0]  data_q;
   logic [LANES-1:0]    mask_q;
   logic                accept;
   logic                lane_en;
   logic                retire;

   // Next-state and lane-walk logic; flush overrides every transition.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      lane_d  = lane_q;
      accept  = 1'b0;
      retire  = 1'b0;
      lane_en = mask_q[lane_q];
      unique case (state_q)
         IDLE: begin
            if (st_valid && !flush) begin
               accept  = 1'b1;
               state_d = WRITE;
               lane_d  = '0;
            end
         end
         WRITE: begin
            // A masked-off lane never waits on memory; an enabled lane waits for mem_ready.
            retire = !lane_en || mem_ready;
            if (retire) begin
               if (lane_q == LAST_LANE) begin
                  state_d = DONE;
                  lane_d  = '0;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            lane_d  = '0;
         end
         default: begin
            state_d = IDLE;
            lane_d  = '0;
         end
      endcase
      if (flush) begin
         state_d = IDLE;
         lane_d  = '0;
      end
   end

   // State, lane index and captured request registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the captured request is reset too, so the memory outputs are provably zero after reset.
         state_q <= IDLE;
         lane_q  <= '0;
         base_q  <= '0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         lane_q  <= lane_d;
         if (accept) begin
            base_q <= st_base;
            data_q <= st_data;
            mask_q <= st_mask;
         end
      end
   end

   // Handshake/status outputs and the byte write port; address wraps modulo 2^ADDR_W.
   assign st_ready  = (state_q == IDLE) && !flush;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE) && !flush;
   assign mem_we    = (state_q == WRITE) && lane_en && !flush;
   assign mem_addr  = mem_we ? (base_q + ADDR_W'(lane_q)) : '0;
   assign mem_wdata = mem_we ? data_q[8*lane_q +: 8] : 8'h00;

endmodule

// File: tb/tb_vector_store_unit.sv
// Self-checking bench for vector_store_unit: directed steps with a write scoreboard.
module tb_vector_store_unit;

   localparam int LANES  = 16;
   localparam int ADDR_W = 12;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic                clk;
   logic                rst_n;
   logic                st_valid;
   logic                st_ready;
   logic [ADDR_W-1:0]   st_base;
   logic [8*LANES-1:0]  st_data;
   logic [LANES-1:0]    st_mask;
   logic                flush;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [7:0]          mem_wdata;
   logic                mem_ready;
   logic                busy;
   logic                done;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   vector_store_unit #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_base   (st_base),
      .st_data   (st_data),
      .st_mask   (st_mask),
      .flush     (flush),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Write monitor: compares each presented write with the scoreboard head, pops on retire.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("write_while_sb_empty", mem_we, 0);
         end else begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            check("mem_wdata", mem_wdata, exp_q[0].data);
            if (mem_ready) void'(exp_q.pop_front());
         end
      end else begin
         check("addr_zero_no_we", mem_addr, 0);
         check("wdata_zero_no_we", mem_wdata, 0);
      end
   end

   task automatic push_expected(input logic [ADDR_W-1:0] base, input logic [8*LANES-1:0] data,
                                input logic [LANES-1:0] mask);
      for (int i = 0; i < LANES; i++)
         if (mask[i]) exp_q.push_back('{addr: base + ADDR_W'(i), data: data[8*i +: 8]});
   endtask

   // Present a request in the current cycle (called at #1 after a rising edge); returns in cycle 1.
   task automatic accept_req(input logic [ADDR_W-1:0] base, input logic [8*LANES-1:0] data,
                             input logic [LANES-1:0] mask);
      push_expected(base, data, mask);
      st_valid = 1'b1;
      st_base  = base;
      st_data  = data;
      st_mask  = mask;
      @(negedge clk);
      check("st_ready_at_accept", st_ready, 1);
      @(posedge clk); #1;
      st_valid = 1'b0;
   endtask

   // Full store: accept, optional stall on one lane, optional junk on st_* while busy, done timing.
   task automatic run_store(input string tag, input logic [ADDR_W-1:0] base,
                            input logic [8*LANES-1:0] data, input logic [LANES-1:0] mask,
                            input int stall_lane, input int exp_done, input bit junk);
      int  n;
      bit  seen;
      accept_req(base, data, mask);
      seen = 1'b0;
      n    = 1;
      while (!seen && n <= 60) begin
         mem_ready = !(stall_lane >= 0 && n >= stall_lane + 1 && n <= stall_lane + 3);
         if (junk) begin
            st_valid = (n >= 2 && n <= 10);
            st_base  = ADDR_W'($urandom);
            st_data  = {$urandom, $urandom, $urandom, $urandom};
            st_mask  = LANES'($urandom);
         end
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      check({tag, "_done_latency"}, n, exp_done);
      check({tag, "_busy_in_done"}, busy, 1);
      @(posedge clk); #1;
      st_valid  = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_idle_after_done"}, busy, 0);
      check({tag, "_ready_after_done"}, st_ready, 1);
      check({tag, "_sb_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [8*LANES-1:0] d;
      int seen_done;

      rst_n     = 1'b0;
      st_valid  = 1'b0;
      st_base   = '0;
      st_data   = '0;
      st_mask   = '0;
      flush     = 1'b0;
      mem_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_st_ready", st_ready, 1);
      check("rst_addr", mem_addr, 0);

      // Base 0x100, bytes 0x00..0x0F, full mask, st_* toggled while busy
      for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(i);
      @(posedge clk); #1;
      run_store("basic", 12'h100, d, 16'hFFFF, -1, 17, 1'b1);

      // Address wrap from 0xFFA
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      run_store("wrap", 12'hFFA, d, 16'hFFFF, -1, 17, 1'b0);

      // Sparse mask: only lanes 4..7 write
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      run_store("sparse", 12'h200, d, 16'h00F0, -1, 17, 1'b0);

      // All-zero mask: no writes, done still at accept+17
      @(posedge clk); #1;
      run_store("nomask", 12'h123, d, 16'h0000, -1, 17, 1'b0);

      // mem_ready low for 3 cycles on lane 5
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      run_store("stall", 12'h300, d, 16'hFFFF, 5, 20, 1'b0);

      // st_valid with flush in IDLE is not accepted
      @(posedge clk); #1;
      st_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      check("flush_blocks_ready", st_ready, 0);
      @(posedge clk); #1;
      st_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      check("flush_valid_not_accepted", busy, 0);

      // Flush in the cycle of the lane 8 write
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      accept_req(12'h400, d, 16'hFFFF);
      for (int n = 1; n < 9; n++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check("flush_gates_we", mem_we, 0);
      check("flush_no_done", done, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy_low", busy, 0);
      check("flush_ready_high", st_ready, 1);
      check("flush_lanes_left", exp_q.size(), 8);
      exp_q.delete();
      seen_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      check("no_done_after_flush", seen_done, 0);

      // Reset during lane 3, then a fresh store completes normally
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      accept_req(12'h500, d, 16'hFFFF);
      for (int n = 1; n < 4; n++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_we", mem_we, 0);
      check("midrst_addr", mem_addr, 0);
      check("midrst_wdata", mem_wdata, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_ready", st_ready, 1);
      check("midrst_lanes_left", exp_q.size(), 12);
      exp_q.delete();
      d = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      run_store("after_rst", 12'h0F8, d, 16'hA5C3, -1, 17, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vector_store_unit.md
VECTOR_STORE_UNIT -- requirements
Module: vector_store_unit

Interface
REQ-001 Parameter: LANES, default 16, number of 8-bit lanes per vector.
REQ-002 Parameter: ADDR_W, default 12, data-memory byte address width.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset; synchronous, active-low.
REQ-005 Port: st_valid  in  1  store request from vector ALU execute stage.
REQ-006 Port: st_ready  out  1  unit can accept a request this cycle.
REQ-007 Port: st_base  in  ADDR_W  byte address for lane 0.
REQ-008 Port: st_data  in  8*LANES  vector result; lane i = bits [8i+7:8i].
REQ-009 Port: st_mask  in  LANES  per-lane write enable; 1 = write lane.
REQ-010 Port: flush  in  1  abort in-flight store, return to IDLE.
REQ-011 Port: mem_we  out  1  byte write strobe to data memory.
REQ-012 Port: mem_addr  out  ADDR_W  byte write address.
REQ-013 Port: mem_wdata  out  8  byte write data.
REQ-014 Port: mem_ready  in  1  memory accepts the write this cycle.
REQ-015 Port: busy  out  1  high in any state other than IDLE.
REQ-016 Port: done  out  1  one-cycle pulse on store completion.

Function
REQ-017 Request accepted on the rising edge where st_valid & st_ready; st_base, st_data, st_mask captured into internal registers that cycle.
REQ-018 st_ready = 1 only in IDLE with flush = 0.
REQ-019 States: IDLE, WRITE, DONE; IDLE->WRITE on accept; WRITE->DONE after last lane retires; DONE->IDLE unconditionally after one cycle.
REQ-020 WRITE walks lane index 0..LANES-1 in ascending order, one lane per cycle at most.
REQ-021 Masked-off lane: no mem_we, lane index advances in one cycle regardless of mem_ready.
REQ-022 Enabled lane: mem_we = 1, mem_addr = st_base + lane index, mem_wdata = lane byte; held stable until mem_ready = 1, lane retires on that edge.
REQ-023 Address arithmetic modulo 2^ADDR_W; 0xFFF + 1 wraps to 0x000.
REQ-024 Latency with mem_ready always 1: first mem_we in cycle after accept; last in cycle accept+LANES; done high in cycle accept+LANES+1.
REQ-025 All-zero mask: LANES cycles in WRITE, no mem_we, then done pulse.
REQ-026 done = 1 only in DONE; mem_we = 0 outside WRITE; mem_addr/mem_wdata = 0 when mem_we = 0.
REQ-027 flush in any state: next state IDLE, lane index 0, no done pulse; a write presented in the flush cycle shall be deasserted that same cycle (mem_we gated by !flush).
REQ-028 st_valid with flush high in IDLE: not accepted.
REQ-029 Captured registers unaffected by st_* inputs while busy.

Reset
REQ-030 rst_n = 0 on a rising edge: state IDLE, lane index 0, captured data/base/mask 0.
REQ-031 Outputs during/after reset: st_ready 1 (once rst_n = 1), mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0.
REQ-032 Reset mid-WRITE: store abandoned, no done pulse, no further writes.

Structure
REQ-033 State enum (IDLE, WRITE, DONE), LANES and ADDR_W defaults placed in shared vector package used by ALU_vectorial and this unit.
REQ-034 Single flat module; lane-byte select is an indexed part-select, no sub-module.
REQ-035 Implementation one FSM process plus combinational output logic; 120-400 RTL lines.

Verification
REQ-036 Base 0x100, data bytes 0x00..0x0F, mask 0xFFFF, mem_ready 1 -> 16 writes addr 0x100..0x10F data 0x00..0x0F consecutive cycles, done at accept+17.
REQ-037 Base 0xFFA, mask 0xFFFF -> addresses 0xFFA..0xFFF then 0x000..0x009.
REQ-038 Mask 0x00F0, base 0x200 -> writes only to 0x204..0x207; done still at accept+17.
REQ-039 mem_ready low 3 cycles on lane 5 -> mem_we/addr/wdata held stable those cycles; done delayed by 3.
REQ-040 flush in cycle of lane 8 write -> mem_we 0 that cycle, busy 0 next, no done, st_ready 1 next cycle.
REQ-041 rst_n low during lane 3 -> next cycle all outputs at reset values; new request then completes normally.
